// File: rtl/ysyx_25040109_axi_arb2_pkg.sv
// Shared encodings for the two-master AXI arbiter: FSM states, owner tags,
// and AXI response codes.
package ysyx_25040109_axi_arb2_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FWD  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  // Owner tag carried in the top ID bit downstream
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_25040109_rr_arb2.sv
// Two-input round-robin picker. On a tie the pointer decides; the pointer
// moves away from whichever input was granted when advance is pulsed.
module ysyx_25040109_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;  // input favoured on a tie

  // Single requester wins outright; a tie goes to the favoured input
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // After a grant, favour the input that did not win
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/ysyx_25040109_axi_arb2.sv
// Two-master AXI4 arbiter in front of the single-port memory queue.
// m0 = instruction fetch (read only), m1 = load/store (read + write).
// One read and one write may be outstanding downstream at a time; the top
// ID bit downstream tags the owner, and the original ID is restored upstream.
module ysyx_25040109_axi_arb2
  import ysyx_25040109_axi_arb2_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic            clock,
  input  logic            reset,
  // master 0 read
  input  logic            m0_arvalid,
  output logic            m0_arready,
  input  logic [AW-1:0]   m0_araddr,
  input  logic [IDW-1:0]  m0_arid,
  input  logic [7:0]      m0_arlen,
  input  logic [2:0]      m0_arsize,
  input  logic [1:0]      m0_arburst,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  output logic [DW-1:0]   m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic [IDW-1:0]  m0_rid,
  output logic            m0_rlast,
  // master 1 read
  input  logic            m1_arvalid,
  output logic            m1_arready,
  input  logic [AW-1:0]   m1_araddr,
  input  logic [IDW-1:0]  m1_arid,
  input  logic [7:0]      m1_arlen,
  input  logic [2:0]      m1_arsize,
  input  logic [1:0]      m1_arburst,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [DW-1:0]   m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic [IDW-1:0]  m1_rid,
  output logic            m1_rlast,
  // master 1 write
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [AW-1:0]   m1_awaddr,
  input  logic [IDW-1:0]  m1_awid,
  input  logic [7:0]      m1_awlen,
  input  logic [2:0]      m1_awsize,
  input  logic [1:0]      m1_awburst,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wlast,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  output logic [1:0]      m1_bresp,
  output logic [IDW-1:0]  m1_bid,
  // downstream
  output logic            s_arvalid,
  input  logic            s_arready,
  output logic [AW-1:0]   s_araddr,
  output logic [IDW-1:0]  s_arid,
  output logic [7:0]      s_arlen,
  output logic [2:0]      s_arsize,
  output logic [1:0]      s_arburst,
  input  logic            s_rvalid,
  output logic            s_rready,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic [IDW-1:0]  s_rid,
  input  logic            s_rlast,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [AW-1:0]   s_awaddr,
  output logic [IDW-1:0]  s_awid,
  output logic [7:0]      s_awlen,
  output logic [2:0]      s_awsize,
  output logic [1:0]      s_awburst,
  output logic            s_wvalid,
  input  logic            s_wready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  output logic            s_wlast,
  input  logic            s_bvalid,
  output logic            s_bready,
  input  logic [1:0]      s_bresp,
  input  logic [IDW-1:0]  s_bid
);

  // ---------------------------------------------------------------- read
  rd_state_t      rd_state, rd_next;
  logic           owner;
  logic [AW-1:0]  ar_addr;
  logic [7:0]     ar_len;
  logic [2:0]     ar_size;
  logic [1:0]     ar_burst;
  logic [IDW-1:0] ar_id;
  logic [1:0]     ar_grant;
  logic           ar_take, rd_done, rd_addr, rd_data, to_m0, to_m1;

  // Downstream IDs only carry our own tag back; steering uses the FSM owner
  logic unused_ids;
  assign unused_ids = ^{s_rid, s_bid};

  ysyx_25040109_rr_arb2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     ({m1_arvalid, m0_arvalid}),
    .advance (ar_take),
    .grant   (ar_grant)
  );

  assign ar_take    = ~reset && (rd_state == RD_IDLE) && (|ar_grant);
  assign m0_arready = ar_take & ar_grant[0];
  assign m1_arready = ar_take & ar_grant[1];

  assign rd_addr = (rd_state == RD_ADDR);
  assign rd_data = (rd_state == RD_DATA);
  assign to_m0   = rd_data && (owner == OWN_IFU);
  assign to_m1   = rd_data && (owner == OWN_LSU);
  assign rd_done = rd_data && s_rvalid && s_rready && s_rlast;

  // Read state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_next;
  end

  // Read next-state: grant -> address -> data until the last beat
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_take)   rd_next = RD_ADDR;
      RD_ADDR: if (s_arready) rd_next = RD_DATA;
      RD_DATA: if (rd_done)   rd_next = RD_IDLE;
      default:                rd_next = RD_IDLE;
    endcase
  end

  // Capture the winning master's request and remember who owns it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner    <= OWN_IFU;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      ar_id    <= '0;
    end else if (ar_take) begin
      owner    <= ar_grant[1];
      ar_addr  <= ar_grant[1] ? m1_araddr  : m0_araddr;
      ar_len   <= ar_grant[1] ? m1_arlen   : m0_arlen;
      ar_size  <= ar_grant[1] ? m1_arsize  : m0_arsize;
      ar_burst <= ar_grant[1] ? m1_arburst : m0_arburst;
      ar_id    <= ar_grant[1] ? m1_arid    : m0_arid;
    end
  end

  assign s_arvalid = rd_addr;
  assign s_araddr  = rd_addr ? ar_addr  : '0;
  assign s_arlen   = rd_addr ? ar_len   : '0;
  assign s_arsize  = rd_addr ? ar_size  : '0;
  assign s_arburst = rd_addr ? ar_burst : '0;
  assign s_arid    = rd_addr ? {owner, ar_id[IDW-2:0]} : '0;

  // R routed only to the owner; everything else reads as zero
  assign m0_rvalid = to_m0 & s_rvalid;
  assign m0_rdata  = to_m0 ? s_rdata : '0;
  assign m0_rresp  = to_m0 ? s_rresp : OKAY;
  assign m0_rid    = to_m0 ? ar_id   : '0;
  assign m0_rlast  = to_m0 & s_rlast;
  assign m1_rvalid = to_m1 & s_rvalid;
  assign m1_rdata  = to_m1 ? s_rdata : '0;
  assign m1_rresp  = to_m1 ? s_rresp : OKAY;
  assign m1_rid    = to_m1 ? ar_id   : '0;
  assign m1_rlast  = to_m1 & s_rlast;
  assign s_rready  = (to_m0 & m0_rready) | (to_m1 & m1_rready);

  // --------------------------------------------------------------- write
  wr_state_t      wr_state, wr_next;
  logic [AW-1:0]  aw_addr;
  logic [7:0]     aw_len;
  logic [2:0]     aw_size;
  logic [1:0]     aw_burst;
  logic [IDW-1:0] aw_id;
  logic           aw_pend, w_done, aw_take, w_ok, w_last_hs, fwd_done, wr_resp;

  assign aw_take    = ~reset && (wr_state == WR_IDLE) && m1_awvalid;
  assign m1_awready = aw_take;
  assign wr_resp    = (wr_state == WR_RESP);

  // W is only opened once AW is latched, and closes after the wlast beat
  assign w_ok      = (wr_state == WR_FWD) && !w_done;
  assign s_wvalid  = w_ok & m1_wvalid;
  assign m1_wready = w_ok & s_wready;
  assign s_wdata   = w_ok ? m1_wdata : '0;
  assign s_wstrb   = w_ok ? m1_wstrb : '0;
  assign s_wlast   = w_ok & m1_wlast;
  assign w_last_hs = s_wvalid & s_wready & m1_wlast;

  // AW and the last W beat may finish in either order or together
  assign fwd_done = (wr_state == WR_FWD) && (!aw_pend || s_awready) &&
                    (w_done || w_last_hs);

  // Write state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_next;
  end

  // Write next-state: accept AW -> forward AW/W -> wait for B
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (aw_take)               wr_next = WR_FWD;
      WR_FWD:  if (fwd_done)              wr_next = WR_RESP;
      WR_RESP: if (s_bvalid && m1_bready) wr_next = WR_IDLE;
      default:                            wr_next = WR_IDLE;
    endcase
  end

  // AW capture plus the two completion flags of the forward phase
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      aw_id    <= '0;
      aw_pend  <= 1'b0;
      w_done   <= 1'b0;
    end else if (aw_take) begin
      aw_addr  <= m1_awaddr;
      aw_len   <= m1_awlen;
      aw_size  <= m1_awsize;
      aw_burst <= m1_awburst;
      aw_id    <= m1_awid;
      aw_pend  <= 1'b1;
      w_done   <= 1'b0;
    end else begin
      if (aw_pend && s_awready) aw_pend <= 1'b0;
      if (w_last_hs)            w_done  <= 1'b1;
    end
  end

  assign s_awvalid = aw_pend;
  assign s_awaddr  = aw_pend ? aw_addr  : '0;
  assign s_awlen   = aw_pend ? aw_len   : '0;
  assign s_awsize  = aw_pend ? aw_size  : '0;
  assign s_awburst = aw_pend ? aw_burst : '0;
  assign s_awid    = aw_pend ? {OWN_LSU, aw_id[IDW-2:0]} : '0;

  assign m1_bvalid = wr_resp & s_bvalid;
  assign m1_bresp  = wr_resp ? s_bresp : OKAY;
  assign m1_bid    = wr_resp ? aw_id   : '0;
  assign s_bready  = wr_resp & m1_bready;

endmodule

// File: tb/tb_ysyx_25040109_axi_arb2.sv
// Directed bench for the two-master AXI arbiter: a table of single reads,
// then hand-written sequences for arbitration, bursts, writes and reset.
module tb_ysyx_25040109_axi_arb2;

  localparam int AW = 32, DW = 32, IDW = 4;

  logic clock = 1'b0, reset;
  logic m0_arvalid, m0_arready; logic [AW-1:0] m0_araddr; logic [IDW-1:0] m0_arid;
  logic [7:0] m0_arlen; logic [2:0] m0_arsize; logic [1:0] m0_arburst;
  logic m0_rvalid, m0_rready; logic [DW-1:0] m0_rdata; logic [1:0] m0_rresp;
  logic [IDW-1:0] m0_rid; logic m0_rlast;
  logic m1_arvalid, m1_arready; logic [AW-1:0] m1_araddr; logic [IDW-1:0] m1_arid;
  logic [7:0] m1_arlen; logic [2:0] m1_arsize; logic [1:0] m1_arburst;
  logic m1_rvalid, m1_rready; logic [DW-1:0] m1_rdata; logic [1:0] m1_rresp;
  logic [IDW-1:0] m1_rid; logic m1_rlast;
  logic m1_awvalid, m1_awready; logic [AW-1:0] m1_awaddr; logic [IDW-1:0] m1_awid;
  logic [7:0] m1_awlen; logic [2:0] m1_awsize; logic [1:0] m1_awburst;
  logic m1_wvalid, m1_wready; logic [DW-1:0] m1_wdata; logic [DW/8-1:0] m1_wstrb; logic m1_wlast;
  logic m1_bvalid, m1_bready; logic [1:0] m1_bresp; logic [IDW-1:0] m1_bid;
  logic s_arvalid, s_arready; logic [AW-1:0] s_araddr; logic [IDW-1:0] s_arid;
  logic [7:0] s_arlen; logic [2:0] s_arsize; logic [1:0] s_arburst;
  logic s_rvalid, s_rready; logic [DW-1:0] s_rdata; logic [1:0] s_rresp;
  logic [IDW-1:0] s_rid; logic s_rlast;
  logic s_awvalid, s_awready; logic [AW-1:0] s_awaddr; logic [IDW-1:0] s_awid;
  logic [7:0] s_awlen; logic [2:0] s_awsize; logic [1:0] s_awburst;
  logic s_wvalid, s_wready; logic [DW-1:0] s_wdata; logic [DW/8-1:0] s_wstrb; logic s_wlast;
  logic s_bvalid, s_bready; logic [1:0] s_bresp; logic [IDW-1:0] s_bid;

  ysyx_25040109_axi_arb2 #(.AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rid(m0_rid), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rid(m1_rid), .m1_rlast(m1_rlast),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_bid(s_bid)
  );

  always #5 clock = ~clock;

  // OR of every DUT output, used for the all-zero reset/idle checks
  logic any_out;
  assign any_out = |{m0_arready, m0_rvalid, m0_rdata, m0_rresp, m0_rid, m0_rlast,
                     m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_rid, m1_rlast,
                     m1_awready, m1_wready, m1_bvalid, m1_bresp, m1_bid,
                     s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
                     s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
                     s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready};

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
    m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
    m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = '0; m1_awburst = '0;
    m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rid = '0; s_rlast = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;
  endtask

  typedef struct {
    bit          mst;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  exp_sarid;   // {owner, id[2:0]}
  } rd_vec_t;

  // One single-beat read through the whole path, checked on both masters
  task automatic run_read(input rd_vec_t v);
    if (v.mst) begin
      m1_arvalid = 1; m1_araddr = v.addr; m1_arid = v.id; m1_arlen = 0; m1_arsize = 2; m1_arburst = 1;
    end else begin
      m0_arvalid = 1; m0_araddr = v.addr; m0_arid = v.id; m0_arlen = 0; m0_arsize = 2; m0_arburst = 1;
    end
    #1;
    chk("arready_winner", v.mst ? m1_arready : m0_arready, 1);
    chk("arready_other", v.mst ? m0_arready : m1_arready, 0);
    tick();
    m0_arvalid = 0; m1_arvalid = 0;
    #1;
    chk("s_arvalid", s_arvalid, 1);
    chk("s_arid", s_arid, v.exp_sarid);
    chk("s_araddr", s_araddr, v.addr);
    s_arready = 1;
    tick();
    s_arready = 0;
    s_rvalid = 1; s_rdata = v.data; s_rresp = v.resp; s_rlast = 1; s_rid = v.exp_sarid;
    m0_rready = 1; m1_rready = 1;
    #1;
    chk("rvalid_owner", v.mst ? m1_rvalid : m0_rvalid, 1);
    chk("rdata_owner", v.mst ? m1_rdata : m0_rdata, v.data);
    chk("rid_owner", v.mst ? m1_rid : m0_rid, v.id);
    chk("rresp_owner", v.mst ? m1_rresp : m0_rresp, v.resp);
    chk("rlast_owner", v.mst ? m1_rlast : m0_rlast, 1);
    chk("rvalid_other", v.mst ? m0_rvalid : m1_rvalid, 0);
    tick();
    s_rvalid = 0; s_rlast = 0; m0_rready = 0; m1_rready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rd_vec_t tv[4];
    tv[0] = '{0, 32'h8000_0000, 4'h3, 32'hDEAD_BEEF, 2'b00, 4'h3};
    tv[1] = '{1, 32'h8000_1000, 4'h5, 32'h1357_9BDF, 2'b00, 4'hD};
    tv[2] = '{0, 32'h8000_2004, 4'hA, 32'h0BAD_F00D, 2'b00, 4'h2};
    tv[3] = '{1, 32'h8000_3008, 4'h9, 32'h5555_AAAA, 2'b10, 4'h9};

    // Reset with live inputs: every output must stay zero
    clear_inputs();
    reset = 1;
    m0_arvalid = 1; m1_awvalid = 1; s_rvalid = 1; s_bvalid = 1;
    #3;
    chk("reset_outputs", any_out, 0);
    #9;
    clear_inputs();
    reset = 0;
    // Stray R/B responses while idle are dropped
    s_rvalid = 1; s_rlast = 1; s_bvalid = 1;
    tick();
    chk("idle_drop", any_out, 0);
    s_rvalid = 0; s_rlast = 0; s_bvalid = 0;

    for (int i = 0; i < 4; i++) run_read(tv[i]);

    // Both masters request continuously: grants alternate strictly
    begin
      int n0 = 0, n1 = 0;
      m0_arvalid = 1; m0_arid = 4'h3; m0_araddr = 32'h8000_00A0;
      m1_arvalid = 1; m1_arid = 4'h5; m1_araddr = 32'h8000_00A1;
      for (int k = 0; k < 6; k++) begin
        bit w;
        w = k[0];
        #1;
        chk("rr_grant", {m1_arready, m0_arready}, w ? 2'b10 : 2'b01);
        tick();
        if (w) begin n1++; if (n1 == 3) m1_arvalid = 0; end
        else begin n0++; if (n0 == 3) m0_arvalid = 0; end
        s_arready = 1;
        #1;
        chk("rr_s_arid", s_arid, w ? 4'hD : 4'h3);
        tick();
        s_arready = 0;
        s_rvalid = 1; s_rlast = 1; s_rdata = 32'hA000_0000 + k; m0_rready = 1; m1_rready = 1;
        #1;
        chk("rr_rdata", w ? m1_rdata : m0_rdata, 32'hA000_0000 + k);
        chk("rr_rid", w ? m1_rid : m0_rid, w ? 4'h5 : 4'h3);
        chk("rr_other_rvalid", w ? m0_rvalid : m1_rvalid, 0);
        chk("rr_no_grant_in_data", {m1_arready, m0_arready}, 2'b00);
        tick();
        s_rvalid = 0; s_rlast = 0; m0_rready = 0; m1_rready = 0;
      end
    end

    // m1 4-beat burst with toggling rready; m0 waits until after rlast
    begin
      logic [31:0] got[4];
      int b = 0, cyc = 0, early = 0;
      bit rr = 1;
      m1_arvalid = 1; m1_arid = 4'h1; m1_arlen = 8'd3; m1_araddr = 32'h8000_4000;
      #1;
      chk("burst_grant", m1_arready, 1);
      tick();
      m1_arvalid = 0;
      m0_arvalid = 1; m0_arid = 4'h7; m0_araddr = 32'h8000_5000; m0_arlen = 0;
      s_arready = 1;
      #1;
      chk("burst_len", s_arlen, 8'd3);
      chk("burst_m0_wait_addr", m0_arready, 0);
      tick();
      s_arready = 0;
      while (b < 4 && cyc < 20) begin
        bit hs;
        m1_rready = rr; s_rvalid = 1; s_rdata = 32'hB000_0000 + b; s_rlast = (b == 3);
        #1;
        if (m0_arready) early++;
        hs = m1_rvalid && m1_rready;
        if (hs) got[b] = m1_rdata;
        tick();
        if (hs) b++;
        rr = ~rr; cyc++;
      end
      s_rvalid = 0; s_rlast = 0; m1_rready = 0;
      chk("burst_beats", b, 4);
      for (int i = 0; i < 4; i++) chk("burst_order", got[i], 32'hB000_0000 + i);
      chk("burst_no_early_grant", early, 0);
      #1;
      chk("grant_after_rlast", m0_arready, 1);
      tick();
      m0_arvalid = 0; s_arready = 1;
      tick();
      s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'h0C0F_FEE0; m0_rready = 1;
      #1;
      chk("m0_after_burst", m0_rdata, 32'h0C0F_FEE0);
      tick();
      s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    end

    // Write with W presented two cycles ahead of AW
    begin
      int wbeats = 0;
      m1_wvalid = 1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF; m1_wlast = 1; s_wready = 1;
      for (int i = 0; i < 2; i++) begin
        #1;
        chk("wready_before_aw", m1_wready, 0);
        chk("s_wvalid_before_aw", s_wvalid, 0);
        tick();
      end
      m1_awvalid = 1; m1_awid = 4'h6; m1_awaddr = 32'h8000_0100;
      #1;
      chk("awready_idle", m1_awready, 1);
      chk("wready_at_aw", m1_wready, 0);
      tick();
      m1_awvalid = 0; s_awready = 1;
      #1;
      chk("s_awvalid", s_awvalid, 1);
      chk("s_awid", s_awid, 4'hE);
      chk("s_awaddr", s_awaddr, 32'h8000_0100);
      chk("s_wdata", s_wdata, 32'h1234_5678);
      chk("s_wstrb", s_wstrb, 4'hF);
      if (s_wvalid && s_wready) wbeats++;
      tick();
      s_awready = 0;
      #1;
      chk("s_awvalid_cleared", s_awvalid, 0);
      if (s_wvalid && s_wready) wbeats++;
      chk("w_beats", wbeats, 1);
      m1_wvalid = 0; m1_wlast = 0;
      s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'hE; m1_bready = 1;
      #1;
      chk("bvalid", m1_bvalid, 1);
      chk("bresp", m1_bresp, 2'b00);
      chk("bid", m1_bid, 4'h6);
      chk("s_bready", s_bready, 1);
      tick();
      #1;
      chk("b_dropped_idle", {m1_bvalid, s_bready}, 2'b00);
      s_bvalid = 0; m1_bready = 0; s_wready = 0;
    end

    // Overlapping read and write from m1
    m1_arvalid = 1; m1_arid = 4'h2; m1_araddr = 32'h8000_6000; m1_arlen = 0;
    m1_awvalid = 1; m1_awid = 4'hB; m1_awaddr = 32'h8000_7000;
    #1;
    chk("ovl_ready", {m1_arready, m1_awready}, 2'b11);
    tick();
    m1_arvalid = 0; m1_awvalid = 0;
    #1;
    chk("ovl_both_out", {s_arvalid, s_awvalid}, 2'b11);
    s_arready = 1; s_awready = 1;
    tick();
    s_arready = 0; s_awready = 0;
    m1_wvalid = 1; m1_wlast = 1; m1_wdata = 32'h0A0B_0C0D; m1_wstrb = 4'h3; s_wready = 1;
    #1;
    chk("ovl_w_after_aw", {s_wvalid, s_wdata}, {1'b1, 32'h0A0B_0C0D});
    tick();
    m1_wvalid = 0; m1_wlast = 0; s_wready = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'hCAFE_F00D; m1_rready = 1;
    s_bvalid = 1; s_bresp = 2'b10; s_bid = 4'hB; m1_bready = 1;
    #1;
    chk("ovl_rdata", {m1_rvalid, m1_rdata, m1_rid}, {1'b1, 32'hCAFE_F00D, 4'h2});
    chk("ovl_b", {m1_bvalid, m1_bresp, m1_bid}, {1'b1, 2'b10, 4'hB});
    tick();
    s_rvalid = 0; s_rlast = 0; m1_rready = 0; s_bvalid = 0; m1_bready = 0;
    #1;
    chk("ovl_idle", any_out, 0);

    // Reset in the middle of an m0 burst
    m0_arvalid = 1; m0_arid = 4'h4; m0_arlen = 8'd3; m0_araddr = 32'h8000_8000;
    tick();
    m0_arvalid = 0; s_arready = 1;
    tick();
    s_arready = 0; s_rvalid = 1; s_rlast = 0; s_rdata = 32'h1111_2222; m0_rready = 1;
    #1;
    chk("pre_reset_beat", m0_rvalid, 1);
    tick();
    #2;
    reset = 1; m1_arvalid = 1; m1_arid = 4'h6; m1_arlen = 0;
    #1;
    chk("async_reset_outputs", any_out, 0);
    s_rvalid = 0; m0_rready = 0;
    @(negedge clock);
    reset = 0;
    #1;
    chk("post_reset_grant", {m1_arready, m0_arready}, 2'b10);
    tick();
    m1_arvalid = 0; s_arready = 1;
    #1;
    chk("post_reset_s_arid", s_arid, 4'hE);
    tick();
    s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'h3333_4444; m1_rready = 1;
    #1;
    chk("post_reset_rdata", {m1_rvalid, m1_rdata, m0_rvalid}, {1'b1, 32'h3333_4444, 1'b0});
    tick();
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
